// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue.
// Holds the PC increment, FSM state encoding and the default entry layout.
package ifq_pkg;

    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

endpackage

// File: rtl/ifq_if.sv
// Fetch-side bus: redirect input, instruction memory port and decode port.
// master = fetch queue, slave = memory/decode environment.
interface ifq_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) ();

    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               out_ready;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready
    );

endinterface

// File: rtl/ifq_fifo.sv
// Registered FIFO of fetched {pc, instr} entries.
// Flush wins over push; pointers wrap modulo DEPTH (power of two).
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  T                       wdata,
    output T                       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties without touching data
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: sequential PC generation, single outstanding imem read, entry queue.
// Optional IFQ_BYPASS_EN: empty-queue ack bypass and back-to-back requests.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic   clk,
    input  logic   reset,
    ifq_if.master  bus
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fe_t;

    state_t                 state;
    logic [ADDR_W-1:0]      fetch_pc;
    logic                   req;
    logic [ADDR_W-1:0]      addr;
    logic [ADDR_W-1:0]      redir_tgt;
    logic                   ack_ok;
    logic                   push;
    logic                   pop;
    fe_t                    wdata;
    fe_t                    head;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic                   chain;

    assign redir_tgt = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    assign ack_ok    = (state == REQ) && bus.imem_ack && !bus.redirect_valid;
    assign wdata     = '{pc: fetch_pc, instr: bus.imem_rdata};
    assign pop       = !empty && bus.out_ready;

`ifdef IFQ_BYPASS_EN
    logic bypass;

    assign bypass        = empty && ack_ok;
    assign push          = ack_ok && !(bypass && bus.out_ready);
    assign bus.out_valid = !empty || bypass;
    assign bus.out_pc    = bypass ? fetch_pc : head.pc;
    assign bus.out_instr = bypass ? bus.imem_rdata : head.instr;
    // Keep requesting only if the entry after this ack still fits
    assign chain = (int'(count) + int'(push) - int'(pop)) < DEPTH;
`else
    logic unused_cnt;

    assign push          = ack_ok;
    assign bus.out_valid = !empty;
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;
    assign chain         = 1'b0;
    assign unused_cnt    = ^count;
`endif

    assign bus.imem_req  = req;
    assign bus.imem_addr = addr;

    ifq_fifo #(
        .DEPTH (DEPTH),
        .T     (fe_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .wdata (wdata),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Fetch FSM: issue, accept or discard the single outstanding read
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req      <= 1'b0;
            addr     <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.redirect_valid) begin
                        fetch_pc <= redir_tgt;
                    end else if (!full) begin
                        req   <= 1'b1;
                        addr  <= fetch_pc;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.redirect_valid) begin
                        fetch_pc <= redir_tgt;
                        if (bus.imem_ack) begin
                            req   <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (bus.imem_ack) begin
                        fetch_pc <= fetch_pc + INC;
                        if (chain) begin
                            addr <= fetch_pc + INC;
                        end else begin
                            req   <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.redirect_valid) begin
                        fetch_pc <= redir_tgt;
                    end
                    if (bus.imem_ack) begin
                        req   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    req   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
